// File: rtl/hack_pkg.sv
// Shared constants for the Hack CPU back end: field bit positions,
// named jump encodings and default datapath widths.
package hack_pkg;

  localparam int HACK_DATA_WIDTH = 16;
  localparam int HACK_PC_WIDTH   = 15;

  // Bit positions inside the 3-bit dest field {d1, d2, d3}
  localparam int DEST_A = 2;
  localparam int DEST_D = 1;
  localparam int DEST_M = 0;

  // Bit positions inside the 3-bit jmp field {j1, j2, j3}
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

  // Named jump mnemonics as they appear in the instruction word
  typedef enum logic [2:0] {
    JNULL = 3'b000,
    JGT   = 3'b001,
    JEQ   = 3'b010,
    JGE   = 3'b011,
    JLT   = 3'b100,
    JNE   = 3'b101,
    JLE   = 3'b110,
    JMP   = 3'b111
  } jump_e;

endpackage

// File: rtl/hack_jump_cond.sv
// Jump condition decoder: turns the jmp field and ALU flags into a
// single taken bit. The flags are trusted exactly as delivered.
module hack_jump_cond
  import hack_pkg::*;
(
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);

  // Each jmp bit selects one of the three mutually exclusive outcomes
  assign taken = (jmp[JMP_LT] & ng)
               | (jmp[JMP_EQ] & zr)
               | (jmp[JMP_GT] & ~ng & ~zr);

endmodule

// File: rtl/hack_writeback_stage.sv
// Hack CPU writeback stage: holds the architectural A, D and PC
// registers, commits one instruction per handshake, resolves jumps
// and buffers a single outstanding data-memory write.
module hack_writeback_stage
  import hack_pkg::*;
#(
  parameter int DATA_WIDTH = HACK_DATA_WIDTH,
  parameter int PC_WIDTH   = HACK_PC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_c,
  input  logic [PC_WIDTH-1:0]   imm,
  input  logic [2:0]            dest,
  input  logic [2:0]            jmp,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  zr,
  input  logic                  ng,
  output logic [DATA_WIDTH-1:0] a_reg,
  output logic [DATA_WIDTH-1:0] d_reg,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  branch_taken,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [PC_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [15:0]           retired
);

  logic                  accept;
  logic                  write_done;
  logic                  load_write;
  logic                  jump_taken;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [PC_WIDTH-1:0]   a_addr;
  logic [PC_WIDTH-1:0]   pc_inc;

  // A free write slot (or one draining this cycle) is all that gates intake
  assign in_ready   = !mem_wr_valid || mem_wr_ready;
  assign accept     = in_valid && in_ready;
  assign write_done = mem_wr_valid && mem_wr_ready;
  assign load_write = accept && is_c && dest[DEST_M];

  assign imm_ext = DATA_WIDTH'(imm);
  assign a_addr  = a_reg[PC_WIDTH-1:0];
  assign pc_inc  = pc + PC_WIDTH'(1);

  hack_jump_cond u_jump_cond (
    .jmp   (jmp),
    .zr    (zr),
    .ng    (ng),
    .taken (jump_taken)
  );

  // Architectural registers and retire counter; jump target and M address use A before this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      d_reg   <= '0;
      pc      <= '0;
      retired <= '0;
    end else if (accept) begin
      retired <= retired + 16'd1;
      if (!is_c) begin
        a_reg <= imm_ext;
        pc    <= pc_inc;
      end else begin
        if (dest[DEST_A]) a_reg <= alu_out;
        if (dest[DEST_D]) d_reg <= alu_out;
        pc <= jump_taken ? a_addr : pc_inc;
      end
    end
  end

  // One-cycle pulse marking that the previous accepted instruction redirected the PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_taken <= 1'b0;
    end else begin
      branch_taken <= accept && is_c && jump_taken;
    end
  end

  // Single-entry M write buffer: reload wins over drain so back-to-back writes see no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_valid <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
    end else if (load_write) begin
      mem_wr_valid <= 1'b1;
      mem_addr     <= a_addr;
      mem_data     <= alu_out;
    end else if (write_done) begin
      mem_wr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hack_writeback_stage.sv
// Self-checking bench for hack_writeback_stage: directed scenarios plus
// random traffic, predicted by an architectural model of the Hack CPU.
module tb_hack_writeback_stage;

  localparam int DW = 16;
  localparam int PW = 15;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          is_c;
  logic [PW-1:0] imm;
  logic [2:0]    dest;
  logic [2:0]    jmp;
  logic [DW-1:0] alu_out;
  logic          zr;
  logic          ng;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] d_reg;
  logic [PW-1:0] pc;
  logic          branch_taken;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic [PW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [15:0]   retired;

  hack_writeback_stage #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_c         (is_c),
    .imm          (imm),
    .dest         (dest),
    .jmp          (jmp),
    .alu_out      (alu_out),
    .zr           (zr),
    .ng           (ng),
    .a_reg        (a_reg),
    .d_reg        (d_reg),
    .pc           (pc),
    .branch_taken (branch_taken),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .retired      (retired)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] d;
    logic [PW-1:0] pc;
    logic [15:0]   ret;
    logic          bt;
    logic          mv;
    logic [PW-1:0] ma;
    logic [DW-1:0] md;
  } exp_t;

  typedef struct {
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  exp_t sq[$];
  wr_t  wq[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic          last_accept;
  logic          rand_ready;

  logic [DW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic [PW-1:0] m_pc;
  logic [15:0]   m_ret;
  logic          m_bt;
  logic          m_pend;
  logic [PW-1:0] m_addr;
  logic [DW-1:0] m_data;

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a wedged DUT still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Architectural meaning of each jump mnemonic in terms of lt / eq / gt
  function automatic logic refTaken(input logic [2:0] j, input logic z, input logic n);
    logic lt, eq, gt;
    lt = n;
    eq = z;
    gt = !n && !z;
    case (j)
      3'b000:  return 1'b0;
      3'b001:  return gt;
      3'b010:  return eq;
      3'b011:  return eq || gt;
      3'b100:  return lt;
      3'b101:  return lt || gt;
      3'b110:  return lt || eq;
      default: return 1'b1;
    endcase
  endfunction

  // Reference model: at each rising edge decide from the inputs what the CPU state becomes
  initial begin
    logic [DW-1:0] a_old;
    logic          ready_now;
    logic          tk;
    wr_t           w;
    exp_t          e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_a = '0; m_d = '0; m_pc = '0; m_ret = '0; m_bt = 1'b0;
        m_pend = 1'b0; m_addr = '0; m_data = '0;
        last_accept = 1'b0;
        sq.delete();
        wq.delete();
      end else begin
        ready_now   = !m_pend || mem_wr_ready;
        if (m_pend && mem_wr_ready) m_pend = 1'b0;
        m_bt        = 1'b0;
        last_accept = 1'b0;
        if (in_valid && ready_now) begin
          last_accept = 1'b1;
          m_ret = m_ret + 16'd1;
          if (!is_c) begin
            m_a  = DW'(imm);
            m_pc = m_pc + PW'(1);
          end else begin
            a_old = m_a;
            if (dest[2]) m_a = alu_out;
            if (dest[1]) m_d = alu_out;
            if (dest[0]) begin
              m_pend = 1'b1;
              m_addr = a_old[PW-1:0];
              m_data = alu_out;
              w.addr = m_addr;
              w.data = m_data;
              wq.push_back(w);
            end
            tk = refTaken(jmp, zr, ng);
            m_pc = tk ? a_old[PW-1:0] : m_pc + PW'(1);
            m_bt = tk;
          end
        end
        e.a = m_a; e.d = m_d; e.pc = m_pc; e.ret = m_ret; e.bt = m_bt;
        e.mv = m_pend; e.ma = m_addr; e.md = m_data;
        sq.push_back(e);
      end
    end
  end

  // Monitor: mid-cycle compare of the DUT against the predicted state and write stream
  initial begin
    exp_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sq.size() > 0) begin
          e = sq.pop_front();
          checkOutput("a_reg", a_reg, e.a);
          checkOutput("d_reg", d_reg, e.d);
          checkOutput("pc", pc, e.pc);
          checkOutput("retired", retired, e.ret);
          checkOutput("branch_taken", branch_taken, e.bt);
          checkOutput("mem_wr_valid", mem_wr_valid, e.mv);
          checkOutput("in_ready", in_ready, !e.mv || mem_wr_ready);
          if (e.mv) begin
            checkOutput("mem_addr_held", mem_addr, e.ma);
            checkOutput("mem_data_held", mem_data, e.md);
          end
        end
        if (mem_wr_valid && mem_wr_ready) begin
          if (wq.size() == 0) begin
            checkOutput("mem_write_unexpected", 1, 0);
          end else begin
            w = wq.pop_front();
            checkOutput("mem_write_addr", mem_addr, w.addr);
            checkOutput("mem_write_data", mem_data, w.data);
          end
        end
      end
    end
  end

  // Random memory back-pressure, enabled only during the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) mem_wr_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present one instruction and hold it until the model reports acceptance
  task automatic applyStimulus(input logic c, input logic [PW-1:0] i, input logic [2:0] d,
                               input logic [2:0] j, input logic [DW-1:0] alu,
                               input logic z, input logic n);
    int waited;
    in_valid = 1'b1;
    is_c     = c;
    imm      = i;
    dest     = d;
    jmp      = j;
    alu_out  = alu;
    zr       = z;
    ng       = n;
    waited   = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!last_accept && waited < 60);
    if (!last_accept) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    checkOutput("rst_a_reg", a_reg, 0);
    checkOutput("rst_d_reg", d_reg, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_branch_taken", branch_taken, 0);
    checkOutput("rst_mem_wr_valid", mem_wr_valid, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_data", mem_data, 0);
    checkOutput("rst_retired", retired, 0);
  endtask

  // Directed scenarios followed by random traffic
  initial begin
    logic [1:0] zn [3];
    zn[0] = 2'b10;
    zn[1] = 2'b01;
    zn[2] = 2'b00;
    rst_n = 1'b0; in_valid = 1'b0; is_c = 1'b0; imm = '0; dest = '0; jmp = '0;
    alu_out = '0; zr = 1'b0; ng = 1'b0; mem_wr_ready = 1'b1; rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset();
    rst_n = 1'b1;

    $display("[TB] reset and A-instruction");
    applyStimulus(1'b0, 15'h1234, 3'b000, 3'b000, 16'h0, 1'b0, 1'b0);

    $display("[TB] C-instruction writing A, D and M");
    applyStimulus(1'b0, 15'h0010, 3'b000, 3'b000, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 15'h0, 3'b111, 3'b000, 16'hFFFF, 1'b0, 1'b1);

    $display("[TB] jump matrix");
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b0, 15'h0100, 3'b000, 3'b000, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 15'h0, 3'b000, 3'(j), 16'($urandom), zn[k][1], zn[k][0]);
      end
    end

    $display("[TB] write stall");
    idle(2);
    mem_wr_ready = 1'b0;
    applyStimulus(1'b0, 15'h0020, 3'b000, 3'b000, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 15'h0, 3'b001, 3'b000, 16'hBEEF, 1'b0, 1'b1);
    fork
      applyStimulus(1'b0, 15'h0333, 3'b000, 3'b000, 16'h0, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        mem_wr_ready = 1'b1;
      end
    join

    $display("[TB] back-to-back M writes");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 15'h0, 3'b101, 3'b000, 16'($urandom), 1'b0, 1'b0);
    end

    $display("[TB] PC wrap and jump with A write");
    applyStimulus(1'b0, 15'h7FFF, 3'b000, 3'b000, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 15'h0, 3'b000, 3'b111, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 15'h0042, 3'b000, 3'b000, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 15'h0, 3'b100, 3'b111, 16'h1357, 1'b0, 1'b0);

    $display("[TB] random traffic");
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 15'($urandom), 3'($urandom), 3'($urandom),
                    16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    mem_wr_ready = 1'b1;
    idle(3);

    $display("[TB] reset during a stall");
    mem_wr_ready = 1'b0;
    applyStimulus(1'b1, 15'h0, 3'b001, 3'b000, 16'h5A5A, 1'b0, 1'b0);
    in_valid = 1'b1;
    is_c     = 1'b0;
    imm      = 15'h0777;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkReset();
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    mem_wr_ready = 1'b1;
    rst_n        = 1'b1;
    applyStimulus(1'b0, 15'h0055, 3'b000, 3'b000, 16'h0, 1'b0, 1'b0);
    idle(4);
    checkOutput("writes_drained", wq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
